// File: rtl/qft_cmd_issuer_if.sv
// qft_cmd_issuer_if
//   Bundles the host command port, the controller strobe/start handshake and
//   the status outputs of qft_cmd_issuer.
//   master : host/controller side (drives commands, strobes, err_clr)
//   slave  : qft_cmd_issuer side (drives cmd_ready, starts, status)
//   Params : DEPTH (FIFO entries), CNT_W (ops_done width)
interface qft_cmd_issuer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_op;
  logic                     w_en_mult;
  logic                     w_en_abs;
  logic                     update_state;
  logic                     err_clr;
  logic                     strt_qft;
  logic                     strt_abs;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         ops_done;
  logic                     err_timeout;
  logic [$clog2(DEPTH):0]   fifo_level;

  modport master (
    output cmd_valid, cmd_op, w_en_mult, w_en_abs, update_state, err_clr,
    input  cmd_ready, strt_qft, strt_abs, busy, done, ops_done, err_timeout,
           fifo_level
  );

  modport slave (
    input  cmd_valid, cmd_op, w_en_mult, w_en_abs, update_state, err_clr,
    output cmd_ready, strt_qft, strt_abs, busy, done, ops_done, err_timeout,
           fifo_level
  );
endinterface

// File: rtl/qft_cmd_issuer.sv
// qft_cmd_issuer
//   Buffers QFT/ABS pass requests in a small FIFO and issues them one at a
//   time to the QFT datapath controller. A start is acknowledged by the
//   matching controller strobe and retired on update_state; a command that
//   is not retired within TIMEOUT cycles of issue is dropped and flagged.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     bus        : qft_cmd_issuer_if.slave (command port, controller
//                  strobes, start requests, status)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no command outstanding; issues the FIFO head when non-empty
//   S_REQ  | strt_qft/strt_abs held high, waiting for the matching strobe
//   S_WAIT | start acknowledged, waiting for update_state to retire
module qft_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  qft_cmd_issuer_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic             mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             strt_qft_q, strt_qft_d;
  logic             strt_abs_q, strt_abs_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             err_q, err_d;

  logic full, push, pop, ack, head_op;

  assign full    = (level_q == LW'(DEPTH));
  // Push is gated by the registered level only, so a full FIFO refuses a
  // push even in a cycle where the head is being popped.
  assign push    = bus.cmd_valid && !full;
  assign head_op = mem[rd_ptr_q];
  // In S_REQ exactly one strt_* is high, so it doubles as the current op.
  assign ack     = (strt_qft_q && bus.w_en_mult) || (strt_abs_q && bus.w_en_abs);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    strt_qft_d = strt_qft_q;
    strt_abs_d = strt_abs_q;
    done_d     = 1'b0;
    ops_d      = ops_q;
    err_d      = err_q;
    pop        = 1'b0;

    if (bus.err_clr) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          state_d    = S_REQ;
          strt_qft_d = !head_op;
          strt_abs_d = head_op;
          tmr_d      = TW'(TIMEOUT - 1);
        end
      end
      S_REQ: begin
        // Expiry beats a late acknowledge: only a retire can save the entry.
        if (tmr_q == '0) begin
          state_d    = S_IDLE;
          strt_qft_d = 1'b0;
          strt_abs_d = 1'b0;
          err_d      = 1'b1;
          pop        = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
          if (ack) begin
            state_d    = S_WAIT;
            strt_qft_d = 1'b0;
            strt_abs_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (bus.update_state) begin
          state_d = S_IDLE;
          ops_d   = ops_q + 1'b1;
          done_d  = 1'b1;
          pop     = 1'b1;
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          pop     = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      strt_qft_q <= 1'b0;
      strt_abs_q <= 1'b0;
      done_q     <= 1'b0;
      ops_q      <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      strt_qft_q <= strt_qft_d;
      strt_abs_q <= strt_abs_d;
      done_q     <= done_d;
      ops_q      <= ops_d;
      err_q      <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.cmd_op;
  end

  assign bus.cmd_ready   = !full;
  assign bus.strt_qft    = strt_qft_q;
  assign bus.strt_abs    = strt_abs_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.ops_done    = ops_q;
  assign bus.err_timeout = err_q;
  assign bus.fifo_level  = level_q;

endmodule

// File: doc/qft_cmd_issuer.md
# qft_cmd_issuer

Command-side sequencer for the QFT datapath controller. It buffers queued operation requests (QFT pass or ABS pass) in a small FIFO and issues them one at a time as `strt_qft` / `strt_abs`. It confirms acceptance through the controller's `w_en_mult` / `w_en_abs` strobes and retires each command on `update_state`. It also keeps a completion count and a sticky timeout flag for the host.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: maximum cycles from issue to completion; ≥4.
- `CNT_W`, 16: width of `ops_done`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_op` in 1: 0 = QFT pass, 1 = ABS pass.
- `w_en_mult` in 1: controller MULT strobe; acknowledges a QFT start.
- `w_en_abs` in 1: controller ABS strobe; acknowledges an ABS start.
- `update_state` in 1: controller completion pulse.
- `err_clr` in 1: clears `err_timeout`.
- `strt_qft` out 1: start request, QFT.
- `strt_abs` out 1: start request, ABS.
- `busy` out 1: state ≠ S_IDLE.
- `done` out 1: one-cycle pulse per retired command.
- `ops_done` out CNT_W: count of successfully retired commands.
- `err_timeout` out 1: sticky timeout flag.
- `fifo_level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs on `cmd_valid && cmd_ready`.
  - A pop occurs only when the FSM retires or drops the head entry.
  - Push and pop in the same cycle leave the level unchanged.
  - When full, `cmd_ready` = 0 and the push is ignored, even if a pop occurs that cycle.
- **State S_IDLE**
  - Stays while FIFO is empty.
  - When FIFO is non-empty, moves to S_REQ.
  - On that edge, registers `strt_qft` = !head_op and `strt_abs` = head_op, and clears the timeout counter.
- **State S_REQ**
  - Holds exactly one of `strt_*` high.
  - Acknowledge is `w_en_mult` for a QFT command, `w_en_abs` for an ABS command.
  - On acknowledge: moves to S_WAIT and drops `strt_*` on the same edge.
  - The non-matching strobe and `update_state` are ignored in S_REQ.
- **State S_WAIT**
  - `strt_*` low.
  - On `update_state`:
    - pop FIFO;
    - `ops_done` += 1, wrapping from all-ones to 0;
    - `done` = 1 for one cycle;
    - go to S_IDLE.
- **Timeout**
  - The counter runs in S_REQ and S_WAIT.
  - If it reaches TIMEOUT−1 with no retire that cycle:
    - pop (drop) the head;
    - set `err_timeout`;
    - drop `strt_*`;
    - go to S_IDLE;
    - no `done`, and `ops_done` is unchanged.
  - If `update_state` in S_WAIT coincides with expiry, completion wins.
- **`err_timeout`**
  - Sticky; cleared only by `err_clr` or reset.
  - If `err_clr` and a new expiry coincide, set wins.
- **Reset**
  - Asserting `rst_n` low at any point, including mid-command, has immediate effect: S_IDLE, FIFO empty.
  - Output values under reset: `strt_*` = 0, `busy` = 0, `done` = 0, `ops_done` = 0, `err_timeout` = 0, `fifo_level` = 0.
  - `cmd_ready` = 1 during reset.

## Timing
- All outputs are registered except `cmd_ready`, which is combinational from the FIFO level.
- Issue latency:
  - A push at edge t gives `fifo_level` = 1 after t.
  - `strt_*` goes high after edge t+1 (from S_IDLE with empty FIFO).
- With the controller idle:
  - `strt_*` high in cycle c → strobe in cycle c+1 → `strt_*` low from cycle c+2.
  - `strt_*` is therefore high for 2 cycles minimum.
  - It stays high indefinitely while the controller sits in INIT or is busy, until acknowledge or timeout.
- The next command's `strt_*` asserts no earlier than 2 cycles after the `update_state` cycle (retire edge, then S_IDLE→S_REQ edge).
- An ABS pass retires 3 cycles after its strobe cycle at the earliest.

## Test plan
- **Reset:**
  - Drive `rst_n` = 0 mid-S_WAIT with 3 FIFO entries.
  - Required: all outputs at reset values immediately, `fifo_level` = 0.
  - After release, a new push issues normally.
- **Single QFT:** use a controller model with N=2 and push op 0.
  - `strt_qft` high exactly 2 cycles.
  - After MULT/ACC×3 and `update_state`: `done` pulses once and `ops_done` = 1.
- **Queue ordering and full:**
  - Push QFT, ABS, QFT, ABS, QFT back-to-back with DEPTH=4.
  - The 5th push is blocked (`cmd_ready` = 0, level = 4).
  - Starts appear in order QFT, ABS, QFT, ABS.
  - The 5th push is accepted after the first retire; `ops_done` = 5 at the end.
- **Timeout in S_REQ:**
  - Push ABS with no `w_en_abs`.
  - Required: `err_timeout` = 1 at the 64th cycle of S_REQ, the entry is dropped, and `ops_done` is unchanged.
  - The next command still issues.
  - `err_clr` clears the flag.
- **Completion vs expiry:**
  - Assert `update_state` in the expiry cycle.
  - Required: `done` = 1, `ops_done` increments, `err_timeout` stays 0.
- **Wrap and wrong strobe:**
  - Preload `ops_done` to 65535 via 65535 ABS commands, or use CNT_W=4 with 15 commands; retire one more, then `ops_done` = 0.
  - A `w_en_mult` during an ABS S_REQ causes no state change.
